// File: rtl/traffic_gen_pkg.sv
// Shared definitions for the traffic generator / read-back checker.
//   tg_state_e      : run sequencer states
//   DEFAULT_NUM_REQ : default number of writes (and then reads) per run
//   DEFAULT_TIMEOUT : default watchdog threshold in idle cycles
//   pattern()       : address-derived write data (low `width` bits of addr)
package traffic_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WWAIT  = 3'd2,
    READ   = 3'd3,
    RDRAIN = 3'd4,
    DONE   = 3'd5
  } tg_state_e;

  localparam int DEFAULT_NUM_REQ = 1024;
  localparam int DEFAULT_TIMEOUT = 200;

  // Data written to (and expected back from) address `addr`. Callers cast
  // the result down to their data width.
  function automatic logic [63:0] pattern(input logic [63:0] addr, input int width);
    if (width >= 64) return addr;
    return addr & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/traffic_gen_checker_read_checker.sv
// Read-response checker.
// Compares every read_done beat against the address-derived pattern of the
// next expected address, counts responses and errors, and latches the
// expected address of the first mismatch.
//   clk, rst_n        : clock, async active-low reset
//   clear             : start of a new run; wipes all state
//   in_run            : sequencer is in WRITE..RDRAIN
//   read_done/data_out: one response beat and its data
//   error_count       : saturating mismatch + stray-response count
//   error_count_next  : value error_count takes at the next edge
//   first_err_addr    : expected address of first mismatch, 0 if none
//   rsp_count         : in-run responses consumed so far
module read_checker
  import traffic_gen_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int address_width = 30,
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_run,
  input  logic                     read_done,
  input  logic [data_width-1:0]    data_out,
  output logic [CNT_W-1:0]         error_count,
  output logic [CNT_W-1:0]         error_count_next,
  output logic [address_width-1:0] first_err_addr,
  output logic [CNT_W-1:0]         rsp_count
);

  localparam logic [CNT_W-1:0] NUM_REQ_C = CNT_W'(NUM_REQ);

  logic [address_width-1:0] exp_addr;
  logic [data_width-1:0]    exp_data;
  logic                     first_seen;
  logic                     in_range;
  logic                     mismatch;
  logic                     stray;

  assign exp_data = data_width'(pattern(64'(exp_addr), data_width));

  // A response is "in range" only while a run still owes us responses;
  // anything else (surplus or outside a run) is a stray and is an error.
  assign in_range = in_run && (rsp_count != NUM_REQ_C);
  assign mismatch = read_done && in_range && (data_out != exp_data);
  assign stray    = read_done && !in_range;

  always_comb begin
    error_count_next = error_count;
    if (clear)
      error_count_next = '0;
    else if ((mismatch || stray) && (error_count != '1))
      error_count_next = error_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_addr       <= '0;
      rsp_count      <= '0;
      first_seen     <= 1'b0;
      first_err_addr <= '0;
      error_count    <= '0;
    end else if (clear) begin
      exp_addr       <= '0;
      rsp_count      <= '0;
      first_seen     <= 1'b0;
      first_err_addr <= '0;
      error_count    <= '0;
    end else begin
      error_count <= error_count_next;
      if (read_done && in_range) begin
        exp_addr  <= exp_addr + 1'b1;
        rsp_count <= rsp_count + 1'b1;
      end
      // Strays never latch an address; only real data mismatches do.
      if (mismatch && !first_seen) begin
        first_seen     <= 1'b1;
        first_err_addr <= exp_addr;
      end
    end
  end

endmodule

// File: rtl/traffic_gen_checker.sv
// Traffic generator and read-back checker for memory_controller.
// On start: writes NUM_REQ sequential addresses with pattern data, waits
// for all write_done pulses, reads the same addresses back, and checks each
// returned word in order (read_checker). A watchdog aborts any stalled run.
//   clk, rst_n            : clock, async active-low reset
//   start                 : run request, honoured in IDLE/DONE only
//   out_busy              : controller back-pressure
//   in_valid, in_request_*: request channel (type 1 = write)
//   write_done, read_done : completion pulses; data_out valid with read_done
//   done, pass, timeout   : run status
//   error_count, first_err_addr, cycle_count : run statistics
//   dbg_state             : current sequencer state (tg_state_e encoding)
//
// Handshake: a request transfers on a rising edge where in_valid=1 and
// out_busy=0. While in_valid=1 and out_busy=1 the type, address and data
// stay unchanged; all request outputs are registered, so out_busy never
// reaches in_valid combinationally.
module traffic_gen_checker
  import traffic_gen_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int address_width = 30,
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     out_busy,
  output logic                     in_valid,
  output logic                     in_request_type,
  output logic [address_width-1:0] in_request_address,
  output logic [data_width-1:0]    in_request_data,
  input  logic                     write_done,
  input  logic                     read_done,
  input  logic [data_width-1:0]    data_out,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [CNT_W-1:0]         error_count,
  output logic [address_width-1:0] first_err_addr,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [2:0]               dbg_state
);

  localparam logic [address_width-1:0] LAST_IDX   = address_width'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]         NUM_REQ_C  = CNT_W'(NUM_REQ);
  localparam logic [CNT_W-1:0]         IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  tg_state_e                state;
  logic [CNT_W-1:0]         wd_cnt;
  logic [CNT_W-1:0]         idle_cnt;
  logic [CNT_W-1:0]         rsp_count;
  logic [CNT_W-1:0]         err_next;
  logic [address_width-1:0] next_addr;
  logic [data_width-1:0]    next_data;
  logic                     run_active;
  logic                     start_ok;
  logic                     accept;
  logic                     activity;
  logic                     wd_fire;

  assign run_active = state inside {WRITE, WWAIT, READ, RDRAIN};
  assign start_ok   = start && (state == IDLE || state == DONE);
  assign accept     = in_valid && !out_busy;
  assign activity   = accept || write_done || read_done;
  // The counter would reach TIMEOUT at this edge; any activity in the same
  // cycle (including a read response) clears it instead.
  assign wd_fire    = run_active && !activity && (idle_cnt == IDLE_LIMIT);
  assign next_addr  = in_request_address + 1'b1;
  assign next_data  = data_width'(pattern(64'(next_addr), data_width));
  assign dbg_state  = state;

  read_checker #(
    .data_width    (data_width),
    .address_width (address_width),
    .NUM_REQ       (NUM_REQ),
    .CNT_W         (CNT_W)
  ) u_read_checker (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (start_ok),
    .in_run           (run_active),
    .read_done        (read_done),
    .data_out         (data_out),
    .error_count      (error_count),
    .error_count_next (err_next),
    .first_err_addr   (first_err_addr),
    .rsp_count        (rsp_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      wd_cnt             <= '0;
      idle_cnt           <= '0;
      cycle_count        <= '0;
      in_valid           <= 1'b0;
      in_request_type    <= 1'b0;
      in_request_address <= '0;
      in_request_data    <= '0;
      done               <= 1'b0;
      pass               <= 1'b0;
      timeout            <= 1'b0;
    end else begin
      if (run_active) cycle_count <= cycle_count + 1'b1;
      if (run_active && write_done) wd_cnt <= wd_cnt + 1'b1;
      if (!run_active || activity) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          // pass tracks late stray responses that bump error_count in DONE.
          if (state == DONE) pass <= (err_next == '0) && !timeout;
          if (start) begin
            state              <= WRITE;
            done               <= 1'b0;
            pass               <= 1'b0;
            timeout            <= 1'b0;
            cycle_count        <= '0;
            wd_cnt             <= '0;
            idle_cnt           <= '0;
            in_valid           <= 1'b1;
            in_request_type    <= 1'b1;
            in_request_address <= '0;
            in_request_data    <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            if (in_request_address == LAST_IDX) begin
              state    <= WWAIT;
              in_valid <= 1'b0;
            end else begin
              in_request_address <= next_addr;
              in_request_data    <= next_data;
            end
          end
        end
        WWAIT: begin
          if (wd_cnt >= NUM_REQ_C) begin
            state              <= READ;
            in_valid           <= 1'b1;
            in_request_type    <= 1'b0;
            in_request_address <= '0;
            in_request_data    <= '0;
          end
        end
        READ: begin
          if (accept) begin
            if (in_request_address == LAST_IDX) begin
              state    <= RDRAIN;
              in_valid <= 1'b0;
            end else begin
              in_request_address <= next_addr;
            end
          end
        end
        RDRAIN: begin
          if (rsp_count == NUM_REQ_C) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= IDLE;
      endcase

      // Watchdog abort overrides whatever the state above decided.
      if (wd_fire) begin
        state    <= DONE;
        done     <= 1'b1;
        timeout  <= 1'b1;
        pass     <= 1'b0;
        in_valid <= 1'b0;
      end
    end
  end

endmodule
